mem_access_unit: RTL

- MEM-stage load/store unit for the MIPS pipeline.
- Replaces the combinational load/store path with a multi-cycle engine on an SRAM-like data bus (req/addr_ok/data_ok).
- Generates pipeline stall, byte-lane strobes, load extraction/extension, address-error exceptions and an optional bus watchdog.
- Sits between the EX/MEM register and the data-side bus bridge.

---
 rtl/mem_access_unit_if.sv | 23 ++
 rtl/mem_access_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit_if.sv
// Data-side SRAM-like bus between the MEM-stage load/store unit and the bus bridge.
// The unit drives the request fields; the bridge returns addr_ok/data_ok and read data.
interface mem_access_unit_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage multi-cycle load/store engine: stall, lane strobes, load extension, address errors, watchdog.
// Define MEM_ADDR_MAP_EN to fold kseg0/kseg1 (vaddr[31:30]=10) onto physical {3'b000, vaddr[28:0]}.
module mem_access_unit #(
  parameter int TIMEOUT_CYC = 0,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [2:0]        op,
  input  logic [31:0]       vaddr,
  input  logic [31:0]       wdata_i,
  input  logic              flush,
  output logic              stall_o,
  output logic              done_o,
  output logic [31:0]       rdata_o,
  output logic              adel_o,
  output logic              ades_o,
  output logic [31:0]       bad_vaddr_o,
  output logic              bus_err_o,
  mem_access_unit_if.master bus
);

  localparam logic [2:0] OP_LB  = 3'd0;
  localparam logic [2:0] OP_LBU = 3'd1;
  localparam logic [2:0] OP_LH  = 3'd2;
  localparam logic [2:0] OP_LHU = 3'd3;
  localparam logic [2:0] OP_LW  = 3'd4;
  localparam logic [2:0] OP_SB  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SW  = 3'd7;

  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;

  typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DONE, ST_DRAIN} state_t;

  state_t            state_reg;
  logic [2:0]        op_reg;
  logic [1:0]        addr_lo_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              data_req_reg;
  logic              data_wr_reg;
  logic [1:0]        data_size_reg;
  logic [31:0]       data_addr_reg;
  logic [3:0]        data_wstrb_reg;
  logic [31:0]       data_wdata_reg;
  logic [31:0]       rdata_reg;
  logic              done_reg;
  logic              bus_err_reg;

  logic              is_store;
  logic [1:0]        size_next;
  logic [3:0]        wstrb_next;
  logic [31:0]       wdata_next;
  logic [31:0]       phys_addr;
  logic              misaligned;
  logic              accept;
  logic              addr_exc;
  logic              resp_now;
  logic              wd_expire;
  logic [7:0]        lane [4];
  logic [31:0]       load_result;

  // Request decode for the instruction currently presented in MEM.
  always_comb begin
    is_store   = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    size_next  = 2'd0;
    wstrb_next = 4'b0000;
    wdata_next = 32'h0;
    case (op)
      OP_LH, OP_LHU: size_next = 2'd1;
      OP_LW:         size_next = 2'd2;
      OP_SB: begin
        size_next  = 2'd0;
        wstrb_next = 4'b0001 << vaddr[1:0];
        wdata_next = {4{wdata_i[7:0]}};
      end
      OP_SH: begin
        size_next  = 2'd1;
        wstrb_next = vaddr[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{wdata_i[15:0]}};
      end
      OP_SW: begin
        size_next  = 2'd2;
        wstrb_next = 4'b1111;
        wdata_next = wdata_i;
      end
      default: size_next = 2'd0;
    endcase
    misaligned = ((size_next == 2'd1) && vaddr[0]) ||
                 ((size_next == 2'd2) && (vaddr[1:0] != 2'b00));
  end

`ifdef MEM_ADDR_MAP_EN
  assign phys_addr = (vaddr[31:30] == 2'b10) ? {3'b000, vaddr[28:0]} : vaddr;
`else
  assign phys_addr = vaddr;
`endif

  assign accept   = (state_reg == ST_IDLE) && req_valid && !flush && !misaligned;
  assign addr_exc = !rst && (state_reg == ST_IDLE) && req_valid && !flush && misaligned;

  assign adel_o      = addr_exc && !is_store;
  assign ades_o      = addr_exc && is_store;
  assign bad_vaddr_o = addr_exc ? vaddr : 32'h0;

  always_comb begin
    stall_o = 1'b0;
    if (!rst) begin
      case (state_reg)
        ST_IDLE:          stall_o = accept;
        ST_REQ, ST_WAIT:  stall_o = 1'b1;
        ST_DRAIN:         stall_o = req_valid;
        default:          stall_o = 1'b0;
      endcase
    end
  end

  // A response only counts once the address phase has been accepted.
  assign resp_now  = bus.data_data_ok &&
                     (((state_reg == ST_REQ) && bus.data_addr_ok) || (state_reg == ST_WAIT));
  assign wd_expire = (TIMEOUT_CYC > 0) && (cnt_reg == CNT_LAST);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane[gi] = bus.data_rdata[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    byte_v      = lane[addr_lo_reg];
    half_v      = addr_lo_reg[1] ? bus.data_rdata[31:16] : bus.data_rdata[15:0];
    load_result = 32'h0;
    case (op_reg)
      OP_LB:   load_result = {{24{byte_v[7]}}, byte_v};
      OP_LBU:  load_result = {24'h0, byte_v};
      OP_LH:   load_result = {{16{half_v[15]}}, half_v};
      OP_LHU:  load_result = {16'h0, half_v};
      OP_LW:   load_result = bus.data_rdata;
      default: load_result = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      op_reg         <= 3'd0;
      addr_lo_reg    <= 2'd0;
      cnt_reg        <= '0;
      data_req_reg   <= 1'b0;
      data_wr_reg    <= 1'b0;
      data_size_reg  <= 2'd0;
      data_addr_reg  <= 32'h0;
      data_wstrb_reg <= 4'b0000;
      data_wdata_reg <= 32'h0;
      rdata_reg      <= 32'h0;
      done_reg       <= 1'b0;
      bus_err_reg    <= 1'b0;
    end else begin
      done_reg    <= 1'b0;
      bus_err_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            state_reg      <= ST_REQ;
            op_reg         <= op;
            addr_lo_reg    <= vaddr[1:0];
            cnt_reg        <= '0;
            data_req_reg   <= 1'b1;
            data_wr_reg    <= is_store;
            data_size_reg  <= size_next;
            data_addr_reg  <= phys_addr;
            data_wstrb_reg <= wstrb_next;
            data_wdata_reg <= wdata_next;
          end
        end
        ST_REQ, ST_WAIT: begin
          cnt_reg <= cnt_reg + 1'b1;
          if ((state_reg == ST_REQ) && bus.data_addr_ok)
            data_req_reg <= 1'b0;
          if (flush) begin
            // Outstanding bus transaction must still complete before the next one.
            state_reg <= resp_now ? ST_IDLE : ST_DRAIN;
          end else if (resp_now) begin
            state_reg <= ST_DONE;
            done_reg  <= 1'b1;
            rdata_reg <= load_result;
          end else if (wd_expire) begin
            state_reg    <= ST_IDLE;
            bus_err_reg  <= 1'b1;
            data_req_reg <= 1'b0;
          end else if ((state_reg == ST_REQ) && bus.data_addr_ok) begin
            state_reg <= ST_WAIT;
          end
        end
        ST_DONE: state_reg <= ST_IDLE;
        ST_DRAIN: begin
          if (bus.data_addr_ok)
            data_req_reg <= 1'b0;
          if (bus.data_data_ok && (!data_req_reg || bus.data_addr_ok)) begin
            state_reg    <= ST_IDLE;
            data_req_reg <= 1'b0;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.data_req   = data_req_reg;
  assign bus.data_wr    = data_wr_reg;
  assign bus.data_size  = data_size_reg;
  assign bus.data_addr  = data_addr_reg;
  assign bus.data_wstrb = data_wstrb_reg;
  assign bus.data_wdata = data_wdata_reg;
  assign rdata_o        = rdata_reg;
  assign done_o         = done_reg;
  assign bus_err_o      = bus_err_reg;

endmodule
